// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: turns clock_lcd rising edges into pixel ticks and
// drives HSYNC/VSYNC/DE/RGB plus look-ahead pixel coordinates for the renderer.
`timescale 1ns/1ps
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int CW       = 10,
  parameter int DW       = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          pixel_en,
  input  logic          clock_lcd,
  input  logic [DW-1:0] pixel_in,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          req_valid,
  output logic          lcd_hsync,
  output logic          lcd_vsync,
  output logic          lcd_de,
  output logic [DW-1:0] lcd_rgb,
  output logic          frame_start
);

  localparam logic [CW-1:0] H_ACT_C      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST_C     = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_ACT_C      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST_C     = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] CNT_ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE_C    = CW'(1);
  localparam logic [DW-1:0] RGB_ZERO_C   = {DW{1'b0}};

  logic          clk_prev_r;
  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] v_cnt_r;

  logic          tick_s;
  logic          h_last_s;
  logic          v_last_s;
  logic [CW-1:0] h_next_s;
  logic [CW-1:0] v_next_s;
  logic          de_now_s;
  logic          hs_now_s;
  logic          vs_now_s;
  logic          origin_s;
  logic          req_valid_s;
  logic [CW-1:0] req_x_s;
  logic [CW-1:0] req_y_s;

  // Tick detection, segment decode and post-advance counter values
  always_comb begin
    tick_s      = 1'b0;
    h_last_s    = 1'b0;
    v_last_s    = 1'b0;
    h_next_s    = h_cnt_r;
    v_next_s    = v_cnt_r;
    de_now_s    = 1'b0;
    hs_now_s    = 1'b0;
    vs_now_s    = 1'b0;
    origin_s    = 1'b0;
    req_valid_s = 1'b0;
    req_x_s     = CNT_ZERO_C;
    req_y_s     = CNT_ZERO_C;

    tick_s   = clock_lcd & ~clk_prev_r & pixel_en;
    h_last_s = (h_cnt_r == H_LAST_C);
    v_last_s = (v_cnt_r == V_LAST_C);
    de_now_s = (h_cnt_r < H_ACT_C) & (v_cnt_r < V_ACT_C);
    hs_now_s = (h_cnt_r >= H_SYNC_BEG_C) & (h_cnt_r < H_SYNC_END_C);
    vs_now_s = (v_cnt_r >= V_SYNC_BEG_C) & (v_cnt_r < V_SYNC_END_C);
    origin_s = (h_cnt_r == CNT_ZERO_C) & (v_cnt_r == CNT_ZERO_C);

    if (h_last_s) begin
      h_next_s = CNT_ZERO_C;
      if (v_last_s) begin
        v_next_s = CNT_ZERO_C;
      end else begin
        v_next_s = v_cnt_r + CNT_ONE_C;
      end
    end else begin
      h_next_s = h_cnt_r + CNT_ONE_C;
      v_next_s = v_cnt_r;
    end

    // Coordinates outside the visible area are clamped so the renderer sees (0,0)
    req_valid_s = (h_next_s < H_ACT_C) & (v_next_s < V_ACT_C);
    if (req_valid_s) begin
      req_x_s = h_next_s;
      req_y_s = v_next_s;
    end else begin
      req_x_s = CNT_ZERO_C;
      req_y_s = CNT_ZERO_C;
    end
  end

  // Raster counters and registered panel/request outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      clk_prev_r  <= 1'b0;
      h_cnt_r     <= CNT_ZERO_C;
      v_cnt_r     <= CNT_ZERO_C;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= RGB_ZERO_C;
      frame_start <= 1'b0;
      req_x       <= CNT_ZERO_C;
      req_y       <= CNT_ZERO_C;
      req_valid   <= 1'b1;
    end else if (!pixel_en) begin
      // Disable always restarts the raster from the origin
      clk_prev_r  <= 1'b0;
      h_cnt_r     <= CNT_ZERO_C;
      v_cnt_r     <= CNT_ZERO_C;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= RGB_ZERO_C;
      frame_start <= 1'b0;
      req_x       <= CNT_ZERO_C;
      req_y       <= CNT_ZERO_C;
      req_valid   <= 1'b1;
    end else begin
      clk_prev_r <= clock_lcd;
      if (tick_s) begin
        h_cnt_r     <= h_next_s;
        v_cnt_r     <= v_next_s;
        lcd_de      <= de_now_s;
        lcd_hsync   <= ~hs_now_s;
        lcd_vsync   <= ~vs_now_s;
        lcd_rgb     <= de_now_s ? pixel_in : RGB_ZERO_C;
        frame_start <= origin_s;
        req_x       <= req_x_s;
        req_y       <= req_y_s;
        req_valid   <= req_valid_s;
      end else begin
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized bench for lcd_timing_gen: a full-size instance and a miniature-raster
// instance share stimulus and are compared every cycle against a tick-count model.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  localparam int CW = 10;
  localparam int DW = 16;
  localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 4, S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam logic [40:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pixel_en = 1'b0;
  logic clock_lcd = 1'b0;
  logic chk_on = 1'b0;
  logic stats_run = 1'b0;

  logic [CW-1:0] req_x0, req_y0, req_x1, req_y1;
  logic          req_valid0, hs0, vs0, de0, fs0;
  logic          req_valid1, hs1, vs1, de1, fs1;
  logic [DW-1:0] rgb0, rgb1, pixel_in0, pixel_in1;

  assign pixel_in0 = {req_y0[7:0], req_x0[7:0]};
  assign pixel_in1 = {req_y1[7:0], req_x1[7:0]};

  wire [40:0] v0 = {req_x0, req_y0, req_valid0, hs0, vs0, de0, rgb0, fs0};
  wire [40:0] v1 = {req_x1, req_y1, req_valid1, hs1, vs1, de1, rgb1, fs1};

  lcd_timing_gen dut0 (
    .Clk(clk), .Rst(rst), .pixel_en(pixel_en), .clock_lcd(clock_lcd), .pixel_in(pixel_in0),
    .req_x(req_x0), .req_y(req_y0), .req_valid(req_valid0), .lcd_hsync(hs0), .lcd_vsync(vs0),
    .lcd_de(de0), .lcd_rgb(rgb0), .frame_start(fs0)
  );

  lcd_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .CW(CW), .DW(DW)
  ) dut1 (
    .Clk(clk), .Rst(rst), .pixel_en(pixel_en), .clock_lcd(clock_lcd), .pixel_in(pixel_in1),
    .req_x(req_x1), .req_y(req_y1), .req_valid(req_valid1), .lcd_hsync(hs1), .lcd_vsync(vs1),
    .lcd_de(de1), .lcd_rgb(rgb1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raster parameters per instance: k selects ha,hfp,hs,hbp,va,vfp,vs,vbp
  function automatic int par(input int i, input int k);
    int full [8];
    int mini [8];
    full = '{480, 2, 41, 2, 272, 2, 10, 2};
    mini = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
    return (i == 0) ? full[k] : mini[k];
  endfunction

  // Expected outputs right after the n-th tick since enable (n counts from 0)
  function automatic logic [40:0] tick_out(input int i, input int n);
    int ha, hss, hse, ht, va, vss, vse, vt, x, y, x1, y1;
    logic de, hs, vs, rv;
    logic [9:0] rx, ry;
    logic [15:0] rgb;
    ha = par(i, 0); hss = ha + par(i, 1); hse = hss + par(i, 2); ht = hse + par(i, 3);
    va = par(i, 4); vss = va + par(i, 5); vse = vss + par(i, 6); vt = vse + par(i, 7);
    x  = n % ht;       y  = (n / ht) % vt;
    x1 = (n + 1) % ht; y1 = ((n + 1) / ht) % vt;
    de = (x < ha) && (y < va);
    hs = !((x >= hss) && (x < hse));
    vs = !((y >= vss) && (y < vse));
    rv = (x1 < ha) && (y1 < va);
    rx = rv ? 10'(x1) : 10'd0;
    ry = rv ? 10'(y1) : 10'd0;
    rgb = de ? {8'(y), 8'(x)} : 16'h0000;
    return {rx, ry, rv, hs, vs, de, rgb, (x == 0) && (y == 0)};
  endfunction

  logic        m_prev;
  int          m_n;
  logic        m_tick;
  logic [40:0] m_out0, m_out1;

  // Reference model: counts ticks since enable and derives outputs from that count
  always @(posedge clk or posedge rst) begin
    if (rst || !pixel_en) begin
      m_prev <= 1'b0;
      m_n    <= 0;
      m_tick <= 1'b0;
      m_out0 <= RST_VEC;
      m_out1 <= RST_VEC;
    end else begin
      m_prev <= clock_lcd;
      if (clock_lcd && !m_prev) begin
        m_tick <= 1'b1;
        m_n    <= m_n + 1;
        m_out0 <= tick_out(0, m_n);
        m_out1 <= tick_out(1, m_n);
      end else begin
        m_tick    <= 1'b0;
        m_out0[0] <= 1'b0;
        m_out1[0] <= 1'b0;
      end
    end
  end

  int idx;
  int de_cnt, hs_cnt, hs_first, fs0_cnt, fs1_cnt, vs_lines, vs_first;

  // Per-cycle comparison and raster statistics observed from the DUT outputs
  always @(negedge clk) begin
    if (chk_on) begin
      check_val("out_full", 64'(v0), 64'(m_out0));
      check_val("out_mini", 64'(v1), 64'(m_out1));
    end
    if (!stats_run) begin
      de_cnt = 0; hs_cnt = 0; hs_first = -1; fs0_cnt = 0; fs1_cnt = 0;
      vs_lines = 0; vs_first = -1;
    end else if (m_tick) begin
      idx = m_n - 1;
      if (idx < 525) begin
        if (de0) de_cnt++;
        if (!hs0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = idx;
        end
        if (fs0) fs0_cnt++;
      end
      if (idx < 240 && fs1) fs1_cnt++;
      if (idx < 120 && (idx % 15) == 0 && !vs1) begin
        vs_lines++;
        if (vs_first < 0) vs_first = idx / 15;
      end
    end
  end

  int period = 6;
  int div = 0;

  // One Clk of stimulus; clock_lcd follows the enable of the previous cycle
  task automatic step(input logic en_nxt);
    @(posedge clk);
    #1;
    if (pixel_en) begin
      clock_lcd = (div < period / 2);
      div = (div == period - 1) ? 0 : div + 1;
    end else begin
      clock_lcd = 1'b0;
      div = 0;
    end
    pixel_en = en_nxt;
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en);
  endtask

  task automatic expect_restart(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      @(negedge clk);
      if (fs0) begin
        found = 1'b1;
        break;
      end
    end
    check_val({tag, "_fs_seen"}, 64'(found), 64'(1));
    check_val({tag, "_de"}, 64'(de0), 64'(1));
    check_val({tag, "_rgb"}, 64'(rgb0), 64'(16'h0000));
    step(1'b1);
    @(negedge clk);
    check_val({tag, "_fs_one_clk"}, 64'(fs0), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

  initial begin
    run(5, 1'b0);
    @(negedge clk);
    check_val("reset_full", 64'(v0), 64'(RST_VEC));
    check_val("reset_mini", 64'(v1), 64'(RST_VEC));
    rst = 1'b0;
    chk_on = 1'b1;

    // Rst mid-frame with a 6-Clk pixel clock, then restart at the origin
    period = 6;
    run(2000, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    run(3, 1'b1);
    @(negedge clk);
    check_val("rst_mid_frame", 64'(v0), 64'(RST_VEC));
    step(1'b1);
    rst = 1'b0;
    expect_restart("t1");

    // One full line of the real panel and two frames of the miniature raster
    run(2, 1'b0);
    period = 2;
    stats_run = 1'b1;
    step(1'b1);
    for (int g = 0; g < 2000 && m_n < 530; g++) step(1'b1);
    check_val("line_ticks_reached", 64'(m_n >= 530), 64'(1));
    check_val("de_ticks_per_line", 64'(de_cnt), 64'(480));
    check_val("hsync_low_ticks", 64'(hs_cnt), 64'(41));
    check_val("hsync_first_tick", 64'(hs_first), 64'(482));
    check_val("frame_start_full", 64'(fs0_cnt), 64'(1));
    check_val("frame_start_mini", 64'(fs1_cnt), 64'(2));
    check_val("vsync_low_lines", 64'(vs_lines), 64'(S_VS));
    check_val("vsync_first_line", 64'(vs_first), 64'(S_VA + S_VFP));
    stats_run = 1'b0;

    // Random pixel-clock periods, raster order checked cycle by cycle
    for (int k = 0; k < 4; k++) begin
      run(2, 1'b0);
      period = $urandom_range(2, 6);
      step(1'b1);
      run($urandom_range(300, 800), 1'b1);
    end

    // Disable mid-frame at line 1 pixel 200, then re-enable
    run(2, 1'b0);
    period = 2;
    step(1'b1);
    for (int g = 0; g < 3000 && m_n < 725; g++) step(1'b1);
    check_val("disable_point_reached", 64'(m_n), 64'(725));
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    check_val("disable_full", 64'(v0), 64'(RST_VEC));
    check_val("disable_mini", 64'(v1), 64'(RST_VEC));
    expect_restart("t5");

    // Disable coincident with a rising clock_lcd, then random enable toggling
    for (int g = 0; g < 20 && !(pixel_en && !clock_lcd && div == 0); g++) step(1'b1);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    check_val("coincident_disable", 64'(v0), 64'(RST_VEC));
    step(1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) step(~pixel_en);
      else step(pixel_en);
    end

    run(3, 1'b0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
